// File: rtl/count_mon_pkg.sv
// Shared types and helpers for the decade count stream monitor.
// The next_bcd helper defines the legal successor of a count, wrapping at max.
package count_mon_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam int MAX_DEFAULT = 9;

  function automatic logic [3:0] next_bcd(input logic [3:0] value, input logic [3:0] max);
    return (value >= max) ? 4'd0 : value + 4'd1;
  endfunction

endpackage

// File: rtl/decade_count_monitor_if.sv
// Sample stream into the monitor plus its status/statistics readout.
// valid is a one-cycle strobe with no ready: every cycle valid is high, Count is consumed; no backpressure exists.
interface decade_count_monitor_if #(
  parameter int ERR_W = 8
);
  logic             valid;
  logic [3:0]       Count;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [ERR_W-1:0] wrap_count;
  logic             fault;
  logic [3:0]       first_bad_value;
  logic [3:0]       first_bad_expected;

  modport master (
    output valid, Count,
    input  locked, err_pulse, err_count, wrap_count, fault,
           first_bad_value, first_bad_expected
  );

  modport slave (
    input  valid, Count,
    output locked, err_pulse, err_count, wrap_count, fault,
           first_bad_value, first_bad_expected
  );
endinterface

// File: rtl/decade_count_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/decade_count_monitor.sv
// Receive-side checker for a BCD count stream: locks to 0..MAX, flags skips,
// repeats and out-of-range samples, and keeps wrap/error statistics plus a sticky first fault.
module decade_count_monitor
  import count_mon_pkg::*;
#(
  parameter int MAX        = MAX_DEFAULT,
  parameter int ERR_W      = 8,
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  decade_count_monitor_if.slave bus,
  output state_t                dbg_state
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  state_t     state, state_nx;
  logic [3:0] prev, prev_nx;
  logic [3:0] exp_q, exp_nx;
  logic       err;
  logic       wrap_inc;
  logic [3:0] bad_exp;
  logic       err_pulse_q;
  logic       fault_q;
  logic [3:0] fbv_q, fbe_q;

  always_comb begin
    state_nx = state;
    prev_nx  = prev;
    exp_nx   = exp_q;
    err      = 1'b0;
    wrap_inc = 1'b0;
    bad_exp  = 4'hF;
    if (bus.valid && !clr) begin
      case (state)
        IDLE: begin
          if (bus.Count <= MAX_V) begin
            state_nx = TRACK;
            prev_nx  = bus.Count;
            exp_nx   = next_bcd(bus.Count, MAX_V);
          end else begin
            err = 1'b1;
          end
        end
        TRACK: begin
          bad_exp = exp_q;
          if (bus.Count == exp_q) begin
            wrap_inc = (prev == MAX_V) && (bus.Count == 4'd0);
            prev_nx  = bus.Count;
            exp_nx   = next_bcd(bus.Count, MAX_V);
          end else if ((bus.Count == prev) && (ALLOW_HOLD == 1'b1)) begin
            state_nx = TRACK;
          end else if (bus.Count <= MAX_V) begin
            // Resynchronise on the bad value so one glitch costs one error.
            err     = 1'b1;
            prev_nx = bus.Count;
            exp_nx  = next_bcd(bus.Count, MAX_V);
          end else begin
            err      = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      prev        <= 4'd0;
      exp_q       <= 4'd0;
      err_pulse_q <= 1'b0;
      fault_q     <= 1'b0;
      fbv_q       <= 4'd0;
      fbe_q       <= 4'd0;
    end else if (clr) begin
      state       <= IDLE;
      prev        <= 4'd0;
      exp_q       <= 4'd0;
      err_pulse_q <= 1'b0;
      fault_q     <= 1'b0;
      fbv_q       <= 4'd0;
      fbe_q       <= 4'd0;
    end else begin
      state       <= state_nx;
      prev        <= prev_nx;
      exp_q       <= exp_nx;
      err_pulse_q <= err;
      if (err && !fault_q) begin
        fault_q <= 1'b1;
        fbv_q   <= bus.Count;
        fbe_q   <= bad_exp;
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err),
    .q   (bus.err_count)
  );

  sat_counter #(.W(ERR_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (wrap_inc),
    .q   (bus.wrap_count)
  );

  assign bus.locked             = (state == TRACK);
  assign bus.err_pulse          = err_pulse_q;
  assign bus.fault              = fault_q;
  assign bus.first_bad_value    = fbv_q;
  assign bus.first_bad_expected = fbe_q;
  assign dbg_state              = state;

endmodule

// File: tb/tb_decade_count_monitor.sv
// Bench for decade_count_monitor: three instances (hold allowed, hold illegal, 2-bit counters)
// share one stimulus stream and are compared against an arithmetic reference model.
module tb_decade_count_monitor;
  import count_mon_pkg::*;

  localparam int MAXV = 9;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] count = 4'd0;

  always #5 clk = ~clk;

  decade_count_monitor_if #(.ERR_W(8)) b0 ();
  decade_count_monitor_if #(.ERR_W(8)) b1 ();
  decade_count_monitor_if #(.ERR_W(2)) b2 ();

  assign b0.valid = valid;
  assign b0.Count = count;
  assign b1.valid = valid;
  assign b1.Count = count;
  assign b2.valid = valid;
  assign b2.Count = count;

  state_t st0, st1, st2;

  decade_count_monitor #(.MAX(MAXV), .ERR_W(8), .ALLOW_HOLD(1'b1)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .bus(b0), .dbg_state(st0));
  decade_count_monitor #(.MAX(MAXV), .ERR_W(8), .ALLOW_HOLD(1'b0)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .bus(b1), .dbg_state(st1));
  decade_count_monitor #(.MAX(MAXV), .ERR_W(2), .ALLOW_HOLD(1'b1)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .bus(b2), .dbg_state(st2));

  logic       lk[3], ep[3], ft[3];
  logic [7:0] ec[3], wc[3];
  logic [3:0] fv[3], fe[3];

  assign lk[0] = b0.locked;    assign lk[1] = b1.locked;    assign lk[2] = b2.locked;
  assign ep[0] = b0.err_pulse; assign ep[1] = b1.err_pulse; assign ep[2] = b2.err_pulse;
  assign ft[0] = b0.fault;     assign ft[1] = b1.fault;     assign ft[2] = b2.fault;
  assign ec[0] = b0.err_count; assign ec[1] = b1.err_count; assign ec[2] = {6'd0, b2.err_count};
  assign wc[0] = b0.wrap_count; assign wc[1] = b1.wrap_count; assign wc[2] = {6'd0, b2.wrap_count};
  assign fv[0] = b0.first_bad_value; assign fv[1] = b1.first_bad_value; assign fv[2] = b2.first_bad_value;
  assign fe[0] = b0.first_bad_expected; assign fe[1] = b1.first_bad_expected;
  assign fe[2] = b2.first_bad_expected;

  // ---------------- reference model ----------------
  int m_hold[3] = '{1, 0, 1};
  int m_lim[3]  = '{255, 255, 3};
  int m_lock[3], m_last[3], m_errc[3], m_wrapc[3];
  int m_fault[3], m_fbv[3], m_fbe[3], m_pulse[3];

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];  // expected dut0 err_count, one entry per observed cycle
  int n_checks = 0;
  int n_pass = 0;

  function automatic string nm(input string s, input int i);
    return $sformatf("d%0d.%s", i, s);
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  task automatic model_clear(input int i);
    m_lock[i] = 0; m_last[i] = 0; m_errc[i] = 0; m_wrapc[i] = 0;
    m_fault[i] = 0; m_fbv[i] = 0; m_fbe[i] = 0; m_pulse[i] = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) model_clear(i);
    exp_q.delete();
    exp_q.push_back(8'd0);
  endtask

  task automatic model_step(input int i, input bit c, input bit v, input int n);
    int expv;
    bit bad;
    m_pulse[i] = 0;
    bad  = 1'b0;
    expv = 15;
    if (c) begin
      model_clear(i);
    end else if (v) begin
      if (m_lock[i] == 0) begin
        if (n > MAXV) bad = 1'b1;
        else begin m_lock[i] = 1; m_last[i] = n; end
      end else begin
        expv = (m_last[i] + 1) % (MAXV + 1);
        if (n == expv) begin
          if (n == 0 && m_wrapc[i] < m_lim[i]) m_wrapc[i]++;
          m_last[i] = n;
        end else if (n == m_last[i] && m_hold[i] == 1) begin
          m_last[i] = n;
        end else begin
          bad = 1'b1;
          if (n > MAXV) m_lock[i] = 0;
          else m_last[i] = n;
        end
      end
      if (bad) begin
        m_pulse[i] = 1;
        if (m_errc[i] < m_lim[i]) m_errc[i]++;
        if (m_fault[i] == 0) begin
          m_fault[i] = 1; m_fbv[i] = n; m_fbe[i] = expv;
        end
      end
    end
    if (i == 0) exp_q.push_back(8'(m_errc[0]));
  endtask

  task automatic check_all();
    logic [7:0] e0;
    for (int i = 0; i < 3; i++) begin
      check(nm("locked", i), int'(lk[i]), m_lock[i]);
      check(nm("err_pulse", i), int'(ep[i]), m_pulse[i]);
      check(nm("wrap_count", i), int'(wc[i]), m_wrapc[i]);
      check(nm("fault", i), int'(ft[i]), m_fault[i]);
      check(nm("first_bad_value", i), int'(fv[i]), m_fbv[i]);
      check(nm("first_bad_expected", i), int'(fe[i]), m_fbe[i]);
      if (i > 0) check(nm("err_count", i), int'(ec[i]), m_errc[i]);
    end
    if (exp_q.size() != 0) begin
      e0 = exp_q.pop_front();
      check("d0.err_count", int'(ec[0]), int'(e0));
    end
    check("d0.state", int'(st0), (m_lock[0] != 0) ? int'(TRACK) : int'(IDLE));
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit c, input bit v, input logic [3:0] n);
    clr = c; valid = v; count = n;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, c, v, int'(n));
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    bit         v;
    logic [3:0] n;
    int         e_lock, e_pulse, e_errc, e_fault, e_fbv, e_fbe;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int r;
    logic [3:0] n;

    // Skip, out-of-range, relock and hold-allowed behaviour of dut0.
    tbl[0]  = '{1'b1, 4'd0,  1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 4'd1,  1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 4'd2,  1, 0, 0, 0, 0, 0};
    tbl[3]  = '{1'b1, 4'd3,  1, 0, 0, 0, 0, 0};
    tbl[4]  = '{1'b1, 4'd5,  1, 1, 1, 1, 5, 4};
    tbl[5]  = '{1'b1, 4'd6,  1, 0, 1, 1, 5, 4};
    tbl[6]  = '{1'b0, 4'd9,  1, 0, 1, 1, 5, 4};
    tbl[7]  = '{1'b1, 4'd7,  1, 0, 1, 1, 5, 4};
    tbl[8]  = '{1'b1, 4'd12, 0, 1, 2, 1, 5, 4};
    tbl[9]  = '{1'b1, 4'd0,  1, 0, 2, 1, 5, 4};
    tbl[10] = '{1'b1, 4'd1,  1, 0, 2, 1, 5, 4};
    tbl[11] = '{1'b1, 4'd1,  1, 0, 2, 1, 5, 4};

    // Reset state
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b1;
    @(negedge clk);

    // Clean stream 0..9,0..9,0
    for (int k = 0; k < 21; k++) step(1'b0, 1'b1, 4'(k % 10));
    check("clean.wrap_count", int'(wc[0]), 2);
    check("clean.err_count", int'(ec[0]), 0);
    check("clean.fault", int'(ft[0]), 0);
    check("clean.locked", int'(lk[0]), 1);

    // Table-driven vectors on dut0
    step(1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, tbl[k].v, tbl[k].n);
      check($sformatf("tbl%0d.locked", k), int'(lk[0]), tbl[k].e_lock);
      check($sformatf("tbl%0d.err_pulse", k), int'(ep[0]), tbl[k].e_pulse);
      check($sformatf("tbl%0d.err_count", k), int'(ec[0]), tbl[k].e_errc);
      check($sformatf("tbl%0d.fault", k), int'(ft[0]), tbl[k].e_fault);
      check($sformatf("tbl%0d.fbv", k), int'(fv[0]), tbl[k].e_fbv);
      check($sformatf("tbl%0d.fbe", k), int'(fe[0]), tbl[k].e_fbe);
    end

    // Hold: 3,4,4 legal with hold allowed, an error without
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd3);
    step(1'b0, 1'b1, 4'd4);
    step(1'b0, 1'b1, 4'd4);
    check("hold.d0_err_count", int'(ec[0]), 0);
    check("hold.d1_err_count", int'(ec[1]), 1);
    check("hold.d1_fbv", int'(fv[1]), 4);
    check("hold.d1_fbe", int'(fe[1]), 5);

    // Saturation on the 2-bit instance, then clr with a simultaneous sample
    step(1'b1, 1'b0, 4'd0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 4'd12);
      pulses += int'(ep[2]);
    end
    check("sat.pulses", pulses, 5);
    check("sat.d2_err_count", int'(ec[2]), 3);
    check("sat.d0_err_count", int'(ec[0]), 5);
    check("sat.d2_fbe_idle", int'(fe[2]), 15);
    step(1'b1, 1'b1, 4'd0);
    check("clr.locked", int'(lk[0]), 0);
    check("clr.err_count", int'(ec[0]), 0);
    check("clr.fault", int'(ft[0]), 0);

    // Asynchronous reset mid-sequence, then relock at 8
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 4'(k));
    step(1'b0, 1'b1, 4'd5);
    step(1'b0, 1'b1, 4'd6);
    #2 rst = 1'b0;
    #1;
    check("arst.locked", int'(lk[0]), 0);
    check("arst.err_count", int'(ec[0]), 0);
    check("arst.fault", int'(ft[0]), 0);
    check("arst.fbv", int'(fv[0]), 0);
    check("arst.fbe", int'(fe[0]), 0);
    model_reset();
    void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1, 4'd8);
    step(1'b0, 1'b1, 4'd9);
    step(1'b0, 1'b1, 4'd0);
    check("relock.err_count", int'(ec[0]), 0);
    check("relock.wrap_count", int'(wc[0]), 1);

    // Randomized stream against the model
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) n = 4'((m_last[0] + 1) % (MAXV + 1));
      else if (r < 8) n = 4'(m_last[0]);
      else n = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decade_count_monitor.md
# decade_count_monitor

Receive-side checker for the 4-bit BCD count stream produced by the decade counter. It samples the count on a strobe, locks to the sequence 0..MAX, and flags any skipped, repeated or out-of-range values. It tracks wrap-arounds and saturating error statistics, and holds a sticky record of the first fault. It sits beside the counter on the FPGA, feeding LEDs or a debug readout.

## Interface
- MAX, 9, terminal count; legal values are 0..MAX, and MAX wraps to 0.
- ERR_W, 8, width of the saturating error and wrap counters.
- ALLOW_HOLD, 1, when 1 a sample equal to the previous value is legal (counter paused); when 0 it is an error.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of statistics, sticky fault and lock.
- valid  in  1  sample strobe; Count is evaluated only when high.
- Count  in  4  BCD value from the counter.
- locked  out  1  high while tracking a legal sequence.
- err_pulse  out  1  one-cycle pulse per erroneous sample.
- err_count  out  ERR_W  saturating count of errors.
- wrap_count  out  ERR_W  saturating count of legal MAX->0 transitions.
- fault  out  1  sticky; set on the first error.
- first_bad_value  out  4  Count at the first error.
- first_bad_expected  out  4  expected value at the first error.

## Operation
- States:
  - IDLE: not locked.
  - TRACK: locked, with an expected value `exp`.
- IDLE, valid:
  - Count<=MAX: go to TRACK, set prev=Count and exp=(Count==MAX)?0:Count+1. No error.
  - Count>MAX: error; stay in IDLE.
- TRACK, valid:
  - Count==exp: legal. Update prev and exp. If prev==MAX and Count==0, increment wrap_count.
  - Count==prev and ALLOW_HOLD=1: legal; no state change.
  - Any other value <=MAX: error, then resync: prev=Count, exp=next(Count), stay in TRACK.
  - Count>MAX: error; go to IDLE.
- Error actions:
  - err_pulse for one cycle.
  - err_count+1, saturating at all-ones.
  - If fault==0: set fault and capture first_bad_value and first_bad_expected. In IDLE the captured expected value is 4'hF.
- valid low: no state or output change; err_pulse low.
- clr: state to IDLE, and every statistic, fault and capture register to 0. A valid sample in the same cycle as clr is discarded.
- Reset precedence: rst > clr > valid.

## Timing
- All outputs are registered. The response to a sample taken at edge N is visible after edge N:
  - locked, err_pulse, counters and captures update one cycle after the sampled input.
- Reset values: state IDLE, and locked, err_pulse, err_count, wrap_count, fault, first_bad_value and first_bad_expected all 0.
- Reset asserted mid-sequence clears immediately (asynchronously). After release, the first valid sample relocks with no error.
- Back-to-back errors on consecutive cycles give consecutive err_pulse cycles, and err_count increments each cycle.
- At saturation the counters hold at 2^ERR_W-1. err_pulse still fires.
- Throughput: one sample per cycle, with no stall.

## Structure
- Package `count_mon_pkg`:
  - state enum {IDLE, TRACK}
  - default MAX constant
  - `next_bcd(value, max)` function
- Sub-module `sat_counter` (parameter W; ports clk, rst, clr, inc, q): instantiated twice, for err_count and wrap_count.
- The top level contains the FSM, the prev/exp registers and the capture logic.

## Test plan
- Reset then a clean stream 0..9,0..9,0, valid every cycle -> locked=1 from the second cycle; wrap_count=2, err_count=0, fault=0.
- Skip: stream 0,1,2,3,5,6 -> one err_pulse after the 5 is sampled; err_count=1, first_bad_value=5, first_bad_expected=4; the 6 is accepted with no further error.
- Out of range: locked at 7, inject 12 -> err_pulse, locked=0, state IDLE. A following 0 relocks with no error.
- Hold handling: repeat 4,4:
  - ALLOW_HOLD=1 -> no error.
  - ALLOW_HOLD=0 -> err_count=1, first_bad_expected=5.
- Saturation with ERR_W=2: five consecutive errors -> err_count=3 and five err_pulses. clr with a simultaneous valid -> all outputs 0 on the next cycle and the sample is ignored.
- rst pulled low mid-sequence (Count=6) -> outputs 0 immediately, without waiting for a clock edge. Release and resume at 8 -> relock with no error.
